// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: datapath widths and MEM/WB writeback
// source encodings used by the WB stage and the EX forwarding path.
package pipeline_pkg;

   localparam int DATA_W  = 32;
   localparam int ADDR_W  = 5;
   localparam int REG_NUM = 32;

   localparam logic [ADDR_W-1:0] REG_ZERO = '0;

   typedef enum logic [1:0] {
      MEM_TO_REG_ALU = 2'b00,
      MEM_TO_REG_MEM = 2'b01,
      MEM_TO_REG_PC4 = 2'b10,
      MEM_TO_REG_IMM = 2'b11
   } mem_to_reg_e;

endpackage

// File: rtl/wb_mux.sv
// 4:1 writeback source select; shared with the EX forwarding path.
module wb_mux
   import pipeline_pkg::*;
#(
   parameter int W = DATA_W
) (
   input  logic [1:0]   i_mem_to_reg,
   input  logic [W-1:0] i_result,
   input  logic [W-1:0] i_mem_read_data,
   input  logic [W-1:0] i_pc_4,
   input  logic [W-1:0] i_imm_ext_out,
   output logic [W-1:0] o_wb_data
);

   always_comb begin
      o_wb_data = '0;
      unique case (mem_to_reg_e'(i_mem_to_reg))
         MEM_TO_REG_ALU: o_wb_data = i_result;
         MEM_TO_REG_MEM: o_wb_data = i_mem_read_data;
         MEM_TO_REG_PC4: o_wb_data = i_pc_4;
         MEM_TO_REG_IMM: o_wb_data = i_imm_ext_out;
         default:        o_wb_data = '0;
      endcase
   end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: selects the WB value, writes the 32x32 register file,
// serves two bypassed ID read ports and keeps retire counters.
module wb_regfile
   import pipeline_pkg::*;
#(
   parameter int DATA_W  = pipeline_pkg::DATA_W,
   parameter int ADDR_W  = pipeline_pkg::ADDR_W,
   parameter int REG_NUM = pipeline_pkg::REG_NUM
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_reg_write,
   input  logic              i_mem_read,
   input  logic [1:0]        i_mem_to_reg,
   input  logic [ADDR_W-1:0] i_write_addr,
   input  logic [DATA_W-1:0] i_result,
   input  logic [DATA_W-1:0] i_mem_read_data,
   input  logic [DATA_W-1:0] i_pc_4,
   input  logic [DATA_W-1:0] i_imm_ext_out,
   input  logic [ADDR_W-1:0] i_read_addr1,
   input  logic [ADDR_W-1:0] i_read_addr2,
   output logic [DATA_W-1:0] o_read_data1,
   output logic [DATA_W-1:0] o_read_data2,
   output logic [DATA_W-1:0] o_wb_data,
   output logic              o_wb_en,
   output logic [31:0]       o_wb_count,
   output logic [31:0]       o_load_count
);

   logic [DATA_W-1:0] regs [REG_NUM];
   logic [31:0]       wb_count_q;
   logic [31:0]       load_count_q;

   wb_mux #(.W(DATA_W)) u_wb_mux (
      .i_mem_to_reg    (i_mem_to_reg),
      .i_result        (i_result),
      .i_mem_read_data (i_mem_read_data),
      .i_pc_4          (i_pc_4),
      .i_imm_ext_out   (i_imm_ext_out),
      .o_wb_data       (o_wb_data)
   );

   assign o_wb_en = i_reg_write && (i_write_addr != REG_ZERO[ADDR_W-1:0]);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
      end else if (o_wb_en) begin
         regs[i_write_addr] <= o_wb_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wb_count_q   <= '0;
         load_count_q <= '0;
      end else begin
         if (o_wb_en) wb_count_q <= wb_count_q + 32'd1;
         if (i_mem_read && i_reg_write) load_count_q <= load_count_q + 32'd1;
      end
   end

   // Reset forces reads to zero even while the bypass condition holds.
   always_comb begin
      o_read_data1 = '0;
      o_read_data2 = '0;
      if (!reset && i_read_addr1 != REG_ZERO[ADDR_W-1:0]) begin
         if (o_wb_en && i_read_addr1 == i_write_addr) o_read_data1 = o_wb_data;
         else                                         o_read_data1 = regs[i_read_addr1];
      end
      if (!reset && i_read_addr2 != REG_ZERO[ADDR_W-1:0]) begin
         if (o_wb_en && i_read_addr2 == i_write_addr) o_read_data2 = o_wb_data;
         else                                         o_read_data2 = regs[i_read_addr2];
      end
   end

   assign o_wb_count   = wb_count_q;
   assign o_load_count = load_count_q;

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Writeback-stage consumer of the MEM/WB pipeline register outputs.
- Selects the writeback value by mem_to_reg and writes it into a 32-entry x 32-bit general register file.
- Serves the two ID-stage read ports with write-through bypass.
- Keeps retired-writeback and retired-load counters for debug and performance observation.

Parameters:
- DATA_W, 32, register and datapath width
- ADDR_W, 5, register address width
- REG_NUM, 32, number of architectural registers (must equal 2**ADDR_W)

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- i_reg_write  in  1  writeback enable from MEM/WB
- i_mem_read  in  1  instruction in WB is a load (counter only)
- i_mem_to_reg  in  2  writeback source select
- i_write_addr  in  ADDR_W  destination register from MEM/WB
- i_result  in  DATA_W  ALU result
- i_mem_read_data  in  DATA_W  load data
- i_pc_4  in  DATA_W  link address (PC+4)
- i_imm_ext_out  in  DATA_W  extended immediate (lui-type)
- i_read_addr1  in  ADDR_W  ID read port 1 address
- i_read_addr2  in  ADDR_W  ID read port 2 address
- o_read_data1  out  DATA_W  read port 1 data (combinational)
- o_read_data2  out  DATA_W  read port 2 data (combinational)
- o_wb_data  out  DATA_W  selected writeback value (combinational, for EX forwarding)
- o_wb_en  out  1  effective write: i_reg_write and i_write_addr != 0
- o_wb_count  out  32  number of effective writes since reset
- o_load_count  out  32  number of retired loads since reset

Behaviour:
- Writeback mux (combinational):
  - 00 -> i_result
  - 01 -> i_mem_read_data
  - 10 -> i_pc_4
  - 11 -> i_imm_ext_out
- Write:
  - On posedge clk, when o_wb_en is 1, regs[i_write_addr] <= o_wb_data.
  - Single write per cycle.
  - Address 0 is never written; regs[0] is constant 0.
- Read ports (combinational):
  - Address 0 -> 0.
  - Else, if o_wb_en and read address == i_write_addr -> o_wb_data (same-cycle write-through bypass).
  - Else -> regs[addr].
  - Both ports are independent; both may bypass in the same cycle.
- Read latency 0. Write visible via bypass in the same cycle and from storage from the next cycle.
- Counters:
  - o_wb_count increments by 1 on each clock edge where o_wb_en is 1.
  - o_load_count increments on each edge where i_mem_read and i_reg_write are 1. A load to x0 still counts as a retired load.
  - Both are 32-bit and wrap 0xFFFFFFFF -> 0 with no flag.
- Reset:
  - Asynchronous; clears all registers and both counters immediately, mid-cycle included.
  - While reset is asserted, o_read_data1/2 = 0 for every address and no write occurs even if o_wb_en is 1.
  - The o_wb_data and o_wb_en outputs stay combinational from their inputs.
  - The first write takes effect on the first posedge after deassertion.
- Inputs X on i_mem_to_reg are not allowed while i_reg_write is 1.

Decomposition:
- Shared package (pipeline_pkg):
  - MEM_TO_REG_ALU=2'b00, MEM_TO_REG_MEM=2'b01, MEM_TO_REG_PC4=2'b10, MEM_TO_REG_IMM=2'b11
  - DATA_W, ADDR_W, and REG_ZERO=0
- One natural sub-module, wb_mux: the 4:1 writeback select. It is reused by the EX forwarding path.
- The register array, bypass and counters stay in wb_regfile.

Test Plan:
- Reset, then read addresses 0..31 on both ports -> all 0; o_wb_count = o_load_count = 0.
- reg_write=1, mem_to_reg=00, addr=5, result=0x12345678; read_addr1=5 in the same cycle -> o_read_data1=0x12345678 (bypass). Next cycle with reg_write=0 -> still 0x12345678; o_wb_count=1.
- Loop over mem_to_reg 00/01/10/11 with result=0xA, mem_data=0xB, pc_4=0xC, imm=0xD to addrs 1..4 -> regs 1..4 read 0xA, 0xB, 0xC, 0xD.
- reg_write=1, addr=0, data=0xFFFFFFFF -> o_wb_en=0, read addr 0 = 0, o_wb_count unchanged. With mem_read=1 in the same cycle -> o_load_count +1.
- Write 0x55 to reg 7; assert reset asynchronously mid-cycle -> o_read_data for addr 7 drops to 0 before the next edge; counters 0.
- Force o_wb_count to 0xFFFFFFFF (backdoor), one effective write -> o_wb_count = 0.
